// File: rtl/chebyshev_sequencer.sv
// Control FSM that walks the coefficient ROM from degree N down to 0 for one sample,
// waits out the datapath pipeline, and hands the captured Horner result downstream.
module chebyshev_sequencer #(
   parameter int S         = 4,
   parameter int N         = 5,
   parameter int SEG_BITS  = 2,
   parameter int ADDR_BITS = 5,
   parameter int CNT_BITS  = 3,
   parameter int FW        = 12,
   parameter int RW        = 34,
   parameter int DP_LAT    = 2
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 sink_valid,
   output logic                 sink_ready,
   input  logic [FW-1:0]        x_in,
   input  logic [SEG_BITS-1:0]  seg_in,
   output logic [FW-1:0]        x_out,
   output logic [ADDR_BITS-1:0] coeff_addr,
   output logic                 dp_load,
   output logic                 dp_en,
   input  logic [RW-1:0]        res_in,
   output logic [RW-1:0]        data_out,
   output logic                 source_valid,
   input  logic                 source_ready,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam logic [CNT_BITS-1:0]  K_MAX   = CNT_BITS'(N);
   localparam logic [CNT_BITS-1:0]  W_MAX   = CNT_BITS'(DP_LAT - 1);
   localparam logic [CNT_BITS-1:0]  CNT_ONE = CNT_BITS'(1);
   localparam logic [SEG_BITS-1:0]  SEG_MAX = SEG_BITS'(S - 1);
   localparam logic [ADDR_BITS-1:0] STRIDE  = ADDR_BITS'(N + 1);

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] k_q, k_d;
   logic [CNT_BITS-1:0] w_q, w_d;
   logic [FW-1:0]       x_q, x_d;
   logic [SEG_BITS-1:0] seg_q, seg_d;
   logic [RW-1:0]       data_q, data_d;
   logic                valid_q, valid_d;

   // Next-state and register update logic for the four-state sequencer.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      w_d     = w_q;
      x_d     = x_q;
      seg_d   = seg_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (sink_valid) begin
               x_d     = x_in;
               seg_d   = (seg_in > SEG_MAX) ? SEG_MAX : seg_in;
               k_d     = K_MAX;
               state_d = ITER;
            end else begin
               state_d = IDLE;
            end
         end
         ITER: begin
            if (k_q == {CNT_BITS{1'b0}}) begin
               w_d     = W_MAX;
               state_d = DRAIN;
            end else begin
               k_d = k_q - CNT_ONE;
            end
         end
         DRAIN: begin
            if (w_q == {CNT_BITS{1'b0}}) begin
               data_d  = res_in;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               w_d = w_q - CNT_ONE;
            end
         end
         OUT: begin
            // data_q is untouched here, so backpressure cannot disturb the result.
            if (source_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath strobes and ROM address, active only while iterating.
   always_comb begin
      dp_en      = 1'b0;
      dp_load    = 1'b0;
      coeff_addr = {ADDR_BITS{1'b0}};
      if (state_q == ITER) begin
         dp_en      = 1'b1;
         dp_load    = (k_q == K_MAX);
         coeff_addr = ADDR_BITS'(seg_q) * STRIDE + ADDR_BITS'(k_q);
      end else begin
         dp_en      = 1'b0;
      end
   end

   // State and data registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         k_q     <= {CNT_BITS{1'b0}};
         w_q     <= {CNT_BITS{1'b0}};
         x_q     <= {FW{1'b0}};
         seg_q   <= {SEG_BITS{1'b0}};
         data_q  <= {RW{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         w_q     <= w_d;
         x_q     <= x_d;
         seg_q   <= seg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign sink_ready   = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign x_out        = x_q;
   assign data_out     = data_q;
   assign source_valid = valid_q;

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Bench for chebyshev_sequencer: four instances (default, DP_LAT=1, DP_LAT=3, S=3), each
// driving a behavioural Horner datapath, checked against a polynomial-sum reference.
module tb_chebyshev_sequencer;

   localparam int NI = 4;
   localparam logic [63:0] MASK = 64'h3_FFFF_FFFF;

   logic        clk;
   logic        resetn;
   logic        sink_valid   [NI];
   logic        sink_ready   [NI];
   logic [11:0] x_in         [NI];
   logic [1:0]  seg_in       [NI];
   logic [11:0] x_out        [NI];
   logic [4:0]  coeff_addr   [NI];
   logic        dp_load      [NI];
   logic        dp_en        [NI];
   logic [33:0] data_out     [NI];
   logic        source_valid [NI];
   logic        source_ready [NI];
   logic        busy         [NI];

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int i);
      return (i == 1) ? 1 : (i == 2) ? 3 : 2;
   endfunction

   function automatic int s_of(input int i);
      return (i == 3) ? 3 : 4;
   endfunction

   function automatic logic [33:0] coef(input int a);
      return 34'((a * 613 + 97) % 4096);
   endfunction

   // Reference: sum of c_k * x^k modulo 2^34 over the clamped segment.
   function automatic logic [63:0] ref_eval(input int x, input int seg, input int s);
      int eff;
      logic [63:0] sum, p;
      eff = (seg >= s) ? s - 1 : seg;
      sum = 64'd0;
      p   = 64'd1;
      for (int j = 0; j <= 5; j++) begin
         sum = (sum + 64'(coef(eff * 6 + j)) * p) & MASK;
         p   = (p * 64'(x)) & MASK;
      end
      return sum;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g
      localparam int LAT = (gi == 1) ? 1 : (gi == 2) ? 3 : 2;
      localparam int SS  = (gi == 3) ? 3 : 4;
      logic [33:0] acc;
      logic [33:0] pipe [3];
      logic [33:0] res;

      chebyshev_sequencer #(
         .S(SS), .N(5), .SEG_BITS(2), .ADDR_BITS(5), .CNT_BITS(3),
         .FW(12), .RW(34), .DP_LAT(LAT)
      ) u_dut (
         .clock(clk), .resetn(resetn),
         .sink_valid(sink_valid[gi]), .sink_ready(sink_ready[gi]),
         .x_in(x_in[gi]), .seg_in(seg_in[gi]), .x_out(x_out[gi]),
         .coeff_addr(coeff_addr[gi]), .dp_load(dp_load[gi]), .dp_en(dp_en[gi]),
         .res_in(res), .data_out(data_out[gi]),
         .source_valid(source_valid[gi]), .source_ready(source_ready[gi]),
         .busy(busy[gi])
      );

      always_ff @(posedge clk) begin
         if (dp_en[gi]) begin
            acc <= dp_load[gi] ? coef(int'(coeff_addr[gi]))
                               : acc * {22'd0, x_out[gi]} + coef(int'(coeff_addr[gi]));
         end
         pipe[0] <= acc;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end

      if (LAT == 1) begin : g_l1
         assign res = acc;
      end else begin : g_ln
         assign res = pipe[LAT-2];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int i);
      chk("rst_sink_ready", 64'(sink_ready[i]), 64'd1);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_source_valid", 64'(source_valid[i]), 64'd0);
      chk("rst_dp_en", 64'(dp_en[i]), 64'd0);
      chk("rst_dp_load", 64'(dp_load[i]), 64'd0);
      chk("rst_coeff_addr", 64'(coeff_addr[i]), 64'd0);
      chk("rst_data_out", 64'(data_out[i]), 64'd0);
      chk("rst_x_out", 64'(x_out[i]), 64'd0);
   endtask

   // One full evaluation; bp = cycles of backpressure after source_valid rises.
   task automatic run_sample(input int i, input logic [11:0] x, input logic [1:0] seg, input int bp);
      int cyc, ne, eff;
      logic [33:0] held;
      eff = (int'(seg) >= s_of(i)) ? s_of(i) - 1 : int'(seg);
      sink_valid[i] = 1'b1;
      x_in[i]       = x;
      seg_in[i]     = seg;
      cyc = 0;
      while (!sink_ready[i] && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("accept_ready", 64'(sink_ready[i]), 64'd1);
      @(posedge clk); #1;
      sink_valid[i] = 1'b0;
      x_in[i]       = 12'($urandom);
      seg_in[i]     = 2'($urandom);
      ne  = 0;
      cyc = 0;
      while (!source_valid[i] && cyc < 40) begin
         if (dp_en[i]) begin
            chk("coeff_addr", 64'(coeff_addr[i]), 64'(eff * 6 + 5 - ne));
            chk("dp_load", 64'(dp_load[i]), 64'(ne == 0));
            ne++;
         end else begin
            chk("addr_drain", 64'(coeff_addr[i]), 64'd0);
         end
         chk("x_out_stable", 64'(x_out[i]), 64'(x));
         chk("sink_ready_busy", 64'(sink_ready[i]), 64'd0);
         @(posedge clk); #1;
         cyc++;
      end
      chk("dp_en_count", 64'(ne), 64'd6);
      chk("valid_latency", 64'(cyc), 64'(6 + lat_of(i)));
      chk("data_out", 64'(data_out[i]), ref_eval(int'(x), int'(seg), s_of(i)));
      held = data_out[i];
      for (int b = 0; b < bp; b++) begin
         sink_valid[i] = 1'b1;
         @(posedge clk); #1;
         chk("bp_valid", 64'(source_valid[i]), 64'd1);
         chk("bp_data", 64'(data_out[i]), 64'(held));
         chk("bp_sink_ready", 64'(sink_ready[i]), 64'd0);
      end
      source_ready[i] = 1'b1;
      sink_valid[i]   = 1'b0;
      @(posedge clk); #1;
      source_ready[i] = 1'b0;
      chk("release_valid", 64'(source_valid[i]), 64'd0);
      chk("release_idle", 64'(sink_ready[i]), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      resetn = 1'b0;
      for (int i = 0; i < NI; i++) begin
         sink_valid[i]   = 1'b0;
         source_ready[i] = 1'b0;
         x_in[i]         = 12'd0;
         seg_in[i]       = 2'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) chk_reset(i);
      resetn = 1'b1;
      @(posedge clk); #1;

      run_sample(0, 12'h800, 2'd2, 0);

      // Back-to-back: accepts every 10 cycles, sink_ready low in between.
      sink_valid[0]   = 1'b1;
      source_ready[0] = 1'b1;
      x_in[0]         = 12'h3A5;
      seg_in[0]       = 2'd1;
      for (int s = 0; s <= 30; s++) begin
         chk("b2b_sink_ready", 64'(sink_ready[0]), 64'(s % 10 == 0));
         if (source_valid[0]) chk("b2b_data", 64'(data_out[0]), ref_eval(12'h3A5, 1, 4));
         @(posedge clk); #1;
      end
      sink_valid[0] = 1'b0;
      cyc = 0;
      while (busy[0] && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      source_ready[0] = 1'b0;
      chk("b2b_drained", 64'(busy[0]), 64'd0);

      run_sample(0, 12'hC3F, 2'd0, 20);
      run_sample(3, 12'h123, 2'd3, 0);

      // Asynchronous reset in the middle of ITER (k=2 -> address 8 for segment 1).
      sink_valid[0] = 1'b1;
      x_in[0]       = 12'h5D1;
      seg_in[0]     = 2'd1;
      @(posedge clk); #1;
      sink_valid[0] = 1'b0;
      cyc = 0;
      while (coeff_addr[0] != 5'd8 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid_iter_addr", 64'(coeff_addr[0]), 64'd8);
      #2;
      resetn = 1'b0;
      #1;
      chk_reset(0);
      #3;
      resetn = 1'b1;
      @(posedge clk); #1;
      run_sample(0, 12'h0F7, 2'd3, 1);

      for (int i = 0; i < NI; i++) begin
         for (int r = 0; r < 8; r++) begin
            run_sample(i, 12'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
